multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the MIPS-lite datapath. It replaces single-cycle control decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. Every memory access waits on a ready handshake, so the shared instruction/data memory can have variable latency. It sits between the instruction register (opcode source) and the datapath muxes, register file, PC and memory port.

---
 rtl/multicycle_ctrl_pkg.sv | 78 +++++++
 rtl/mctrl_out_decode.sv | 91 +++++++++
 rtl/multicycle_ctrl.sv | 123 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the multi-cycle controller.
// TRAP exists only when MCTRL_ILLEGAL_TRAP_EN is defined.
package multicycle_ctrl_pkg;

  localparam int ALU_OP_LENGTH = 2;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_JAL    = 6'b000011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_FUNCT = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    EXEC_ORI = 4'd4,
    WB_I     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    WB_MEM   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11
`ifdef MCTRL_ILLEGAL_TRAP_EN
    ,TRAP    = 4'd12
`endif
  } state_t;

  typedef struct packed {
    logic                     mem_req;
    logic                     mem_we;
    logic                     i_or_d;
    logic                     ir_write;
    logic                     pc_write;
    logic                     pc_write_cond;
    logic [1:0]               pc_source;
    logic                     alu_src_a;
    logic [1:0]               alu_src_b;
    logic [ALU_OP_LENGTH-1:0] alu_op;
    logic                     extend_op;
    logic                     reg_write;
    logic [1:0]               reg_dst;
    logic [1:0]               mem_to_reg;
    logic                     mdr_write;
    logic                     instr_done;
  } ctrl_t;

  function automatic logic is_defined_op(input logic [5:0] op);
    return (op == OP_R_TYPE) || (op == OP_ORI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mctrl_out_decode.sv
// Combinational state-to-control-word table; ungated Moore values.
// Ready gating and reset masking are applied by the top level.
module mctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
      end
      DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        ctrl.extend_op = 1'b1;
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      EXEC_ORI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OR;
      end
      WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.extend_op = 1'b1;
      end
      MEM_RD: begin
        ctrl.mem_req   = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.mdr_write = 1'b1;
      end
      WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_we     = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_SRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RA;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the MIPS-lite multi-cycle datapath with ready-gated memory states.
// Define MCTRL_ILLEGAL_TRAP_EN to trap undefined opcodes instead of treating them as NOPs.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = ALU_OP_LENGTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                extend_op,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                mdr_write,
  output logic                instr_done,
  output logic                illegal_op
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  word;
  logic   op_ok;
  logic   ready_gate;
  logic   nop_done;
  logic   illegal_flag;

  // The datapath qualifies pc_write_cond with zero itself.
  logic unused_zero;
  assign unused_zero = &{1'b0, zero};

  assign op_ok = is_defined_op(op);

  mctrl_out_decode u_decode (
    .state (state_reg),
    .ctrl  (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_R_TYPE:     state_next = EXEC_R;
          OP_ORI:        state_next = EXEC_ORI;
          OP_LW, OP_SW:  state_next = MEM_ADDR;
          OP_BEQ:        state_next = BRANCH;
          OP_JAL:        state_next = JAL;
`ifdef MCTRL_ILLEGAL_TRAP_EN
          default:       state_next = TRAP;
`else
          default:       state_next = FETCH;
`endif
        endcase
      end
      EXEC_R:   state_next = WB_R;
      EXEC_ORI: state_next = WB_I;
      MEM_ADDR: state_next = (op == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_next = WB_MEM;
      MEM_WR:   if (mem_ready) state_next = FETCH;
      WB_R, WB_I, WB_MEM, BRANCH, JAL: state_next = FETCH;
`ifdef MCTRL_ILLEGAL_TRAP_EN
      TRAP:     state_next = TRAP;
`endif
      default:  state_next = FETCH;
    endcase
  end

`ifdef MCTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_flag <= 1'b0;
    else if (state_reg == DECODE && !op_ok) illegal_flag <= 1'b1;
  end
  assign nop_done = 1'b0;
`else
  assign illegal_flag = 1'b0;
  assign nop_done     = (state_reg == DECODE) && !op_ok;
`endif

  assign ready_gate = ((state_reg == FETCH) || (state_reg == MEM_RD) ||
                       (state_reg == MEM_WR)) ? mem_ready : 1'b1;

  // Whole control word is masked while reset is held low.
  always_comb begin
    mem_req       = rst_n & word.mem_req;
    mem_we        = rst_n & word.mem_we;
    i_or_d        = rst_n & word.i_or_d;
    ir_write      = rst_n & word.ir_write & ready_gate;
    pc_write      = rst_n & word.pc_write & ready_gate;
    pc_write_cond = rst_n & word.pc_write_cond;
    pc_source     = rst_n ? word.pc_source : 2'b00;
    alu_src_a     = rst_n & word.alu_src_a;
    alu_src_b     = rst_n ? word.alu_src_b : 2'b00;
    alu_op        = rst_n ? word.alu_op : '0;
    extend_op     = rst_n & word.extend_op;
    reg_write     = rst_n & word.reg_write;
    reg_dst       = rst_n ? word.reg_dst : 2'b00;
    mem_to_reg    = rst_n ? word.mem_to_reg : 2'b00;
    mdr_write     = rst_n & word.mdr_write & ready_gate;
    instr_done    = rst_n & ((word.instr_done & ready_gate) | nop_done);
    illegal_op    = rst_n & illegal_flag;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: cycle counts, per-state control words, waits, reset, illegal op.
// Honours MCTRL_ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic       alu_src_a, extend_op, reg_write, mdr_write, instr_done, illegal_op;

  int tests = 0;
  int fails = 0;
  int ir_cnt, mdr_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .extend_op(extend_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .mdr_write(mdr_write), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  // {mem_req,we,i_or_d}_{ir_w,pc_w,pc_cond}_pcsrc_a_b_aluop_ext_regw_dst_m2r_mdrw_done
  localparam logic [20:0] W_ZERO     = 21'b000_000_00_0_00_00_0_0_00_00_0_0;
  localparam logic [20:0] W_FETCH_R  = 21'b100_110_00_0_01_00_0_0_00_00_0_0;
  localparam logic [20:0] W_FETCH_W  = 21'b100_000_00_0_01_00_0_0_00_00_0_0;
  localparam logic [20:0] W_DECODE   = 21'b000_000_00_0_11_00_1_0_00_00_0_0;
  localparam logic [20:0] W_DEC_NOP  = 21'b000_000_00_0_11_00_1_0_00_00_0_1;
  localparam logic [20:0] W_EXEC_R   = 21'b000_000_00_1_00_11_0_0_00_00_0_0;
  localparam logic [20:0] W_WB_R     = 21'b000_000_00_0_00_00_0_1_01_00_0_1;
  localparam logic [20:0] W_EXEC_ORI = 21'b000_000_00_1_10_10_0_0_00_00_0_0;
  localparam logic [20:0] W_WB_I     = 21'b000_000_00_0_00_00_0_1_00_00_0_1;
  localparam logic [20:0] W_MEM_ADDR = 21'b000_000_00_1_10_00_1_0_00_00_0_0;
  localparam logic [20:0] W_MEM_RD_R = 21'b101_000_00_0_00_00_0_0_00_00_1_0;
  localparam logic [20:0] W_MEM_RD_W = 21'b101_000_00_0_00_00_0_0_00_00_0_0;
  localparam logic [20:0] W_WB_MEM   = 21'b000_000_00_0_00_00_0_1_00_01_0_1;
  localparam logic [20:0] W_MEM_WR_R = 21'b111_000_00_0_00_00_0_0_00_00_0_1;
  localparam logic [20:0] W_MEM_WR_W = 21'b111_000_00_0_00_00_0_0_00_00_0_0;
  localparam logic [20:0] W_BRANCH   = 21'b000_001_01_1_00_01_0_0_00_00_0_1;
  localparam logic [20:0] W_JAL      = 21'b000_010_10_0_00_00_0_1_10_10_0_1;

  function automatic logic [20:0] obs();
    return {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
            alu_src_a, alu_src_b, alu_op, extend_op, reg_write, reg_dst, mem_to_reg,
            mdr_write, instr_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock of a directed trace: drive ready, check the word, count pulses, advance.
  task automatic cyc(input string tag, input logic r, input logic [20:0] exp);
    mem_ready = r;
    #1;
    chk(tag, {11'd0, obs()}, {11'd0, exp});
    $display("[TB] %s ready=%0b word=%b", tag, r, obs());
    ir_cnt  += int'(ir_write);
    mdr_cnt += int'(mdr_write);
    @(posedge clk);
    #1;
  endtask

  // Zero-wait instruction from FETCH; counts cycles up to and including instr_done.
  task automatic count_instr(input string tag, input logic [5:0] o, input int expected);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    op = o;
    mem_ready = 1'b1;
    while (!done && n < 50) begin
      #1;
      n++;
      done = instr_done;
      @(posedge clk);
      #1;
    end
    chk(tag, n, expected);
    $display("[TB] %s op=%b cycles=%0d", tag, o, n);
  endtask

  initial begin
    rst_n = 1'b0;
    op = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b1;
    ir_cnt = 0;
    mdr_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_word", {11'd0, obs()}, {11'd0, W_ZERO});
    chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
    rst_n = 1'b1;
    cyc("post_reset_fetch", 1'b0, W_FETCH_W);

    count_instr("cnt_r",   6'b000000, 4);
    count_instr("cnt_ori", 6'b001101, 4);
    count_instr("cnt_lw",  6'b100011, 5);
    count_instr("cnt_sw",  6'b101011, 4);
    zero = 1'b1;
    count_instr("cnt_beq", 6'b000100, 3);
    count_instr("cnt_jal", 6'b000011, 3);

    op = 6'b000000;
    cyc("r_fetch", 1'b1, W_FETCH_R);
    cyc("r_decode", 1'b1, W_DECODE);
    cyc("r_exec", 1'b1, W_EXEC_R);
    cyc("r_wb", 1'b1, W_WB_R);
    op = 6'b001101;
    cyc("ori_fetch", 1'b1, W_FETCH_R);
    cyc("ori_decode", 1'b1, W_DECODE);
    cyc("ori_exec", 1'b1, W_EXEC_ORI);
    cyc("ori_wb", 1'b1, W_WB_I);
    op = 6'b101011;
    cyc("sw_fetch", 1'b1, W_FETCH_R);
    cyc("sw_decode", 1'b1, W_DECODE);
    cyc("sw_addr", 1'b1, W_MEM_ADDR);
    cyc("sw_memwr", 1'b1, W_MEM_WR_R);
    op = 6'b000100;
    zero = 1'b1;
    cyc("beq1_fetch", 1'b1, W_FETCH_R);
    cyc("beq1_decode", 1'b1, W_DECODE);
    cyc("beq1_branch", 1'b1, W_BRANCH);
    op = 6'b000011;
    cyc("jal_fetch", 1'b1, W_FETCH_R);
    cyc("jal_decode", 1'b1, W_DECODE);
    cyc("jal_jal", 1'b1, W_JAL);

    // LW with 3 FETCH waits and 2 MEM_RD waits: 10 cycles total.
    op = 6'b100011;
    ir_cnt = 0;
    mdr_cnt = 0;
    cyc("lww_fetch_w0", 1'b0, W_FETCH_W);
    cyc("lww_fetch_w1", 1'b0, W_FETCH_W);
    cyc("lww_fetch_w2", 1'b0, W_FETCH_W);
    cyc("lww_fetch_r", 1'b1, W_FETCH_R);
    cyc("lww_decode", 1'b0, W_DECODE);
    cyc("lww_addr", 1'b0, W_MEM_ADDR);
    cyc("lww_rd_w0", 1'b0, W_MEM_RD_W);
    cyc("lww_rd_w1", 1'b0, W_MEM_RD_W);
    cyc("lww_rd_r", 1'b1, W_MEM_RD_R);
    cyc("lww_wb", 1'b0, W_WB_MEM);
    chk("lww_ir_pulses", ir_cnt, 1);
    chk("lww_mdr_pulses", mdr_cnt, 1);

    // BEQ not taken: same strobes, next cycle is FETCH.
    op = 6'b000100;
    zero = 1'b0;
    cyc("beq0_fetch", 1'b1, W_FETCH_R);
    cyc("beq0_decode", 1'b1, W_DECODE);
    cyc("beq0_branch", 1'b1, W_BRANCH);
    cyc("beq0_next_fetch", 1'b0, W_FETCH_W);
    cyc("beq0_fetch2", 1'b1, W_FETCH_R);

    // Reset dropped while MEM_WR waits on memory.
    op = 6'b000011;
    cyc("pre_sw_done_jal_decode", 1'b1, W_DECODE);
    cyc("pre_sw_done_jal", 1'b1, W_JAL);
    op = 6'b101011;
    cyc("rsw_fetch", 1'b1, W_FETCH_R);
    cyc("rsw_decode", 1'b1, W_DECODE);
    cyc("rsw_addr", 1'b0, W_MEM_ADDR);
    cyc("rsw_wait", 1'b0, W_MEM_WR_W);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rsw_in_reset", {11'd0, obs()}, {11'd0, W_ZERO});
    @(posedge clk);
    #1;
    chk("rsw_reset_next", {11'd0, obs()}, {11'd0, W_ZERO});
    chk("rsw_no_regwrite", {31'd0, reg_write}, 32'd0);
    rst_n = 1'b1;
    cyc("rsw_release_fetch", 1'b0, W_FETCH_W);

    // Undefined opcode.
    op = 6'b111111;
    cyc("ill_fetch", 1'b1, W_FETCH_R);
`ifdef MCTRL_ILLEGAL_TRAP_EN
    cyc("ill_decode", 1'b1, W_DECODE);
    for (int i = 0; i < 3; i++) begin
      chk("trap_illegal", {31'd0, illegal_op}, 32'd1);
      cyc("trap_hold", 1'b1, W_ZERO);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("trap_reset_clear", {31'd0, illegal_op}, 32'd0);
    rst_n = 1'b1;
    op = 6'b000000;
    cyc("trap_after_fetch", 1'b0, W_FETCH_W);
`else
    cyc("ill_decode_nop", 1'b1, W_DEC_NOP);
    chk("ill_no_flag", {31'd0, illegal_op}, 32'd0);
    cyc("ill_back_fetch", 1'b0, W_FETCH_W);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
